// File: rtl/stack_unit.sv
// stack_unit: hardware LIFO for the CPU push/pop decoder strobes.
// A single-write, single-read synchronous RAM holds the entries. sp is the
// entry count. The popped word is registered into q. Sticky overflow and
// underflow flags report pushes to a full stack and pops from an empty stack.
module stack_unit #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 128,
   parameter int AW    = 7
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hold,
   input  logic             clear,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic [AW:0]      level,
   output logic             empty,
   output logic             full,
   output logic             overflow,
   output logic             underflow
);

   localparam logic [AW:0]   SP_ONE   = (AW+1)'(1);
   localparam logic [AW:0]   SP_DEPTH = (AW+1)'(DEPTH);
   localparam logic [AW-1:0] ADDR_ONE = AW'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW:0]      sp_q, sp_d;
   logic             ovf_q, ovf_d;
   logic             unf_q, unf_d;
   logic [WIDTH-1:0] q_q;

   logic             op_push, op_pop;
   logic             push_ok, pop_ok, pop_empty;
   logic [AW-1:0]    wr_addr, rd_addr;

   // Status decodes and strobe qualification. clear beats hold. hold beats the strobes.
   // A simultaneous push+pop is dropped as a no-op.
   assign empty     = (sp_q == '0);
   assign full      = (sp_q == SP_DEPTH);
   assign op_push   = ~clear & ~hold & push & ~pop;
   assign op_pop    = ~clear & ~hold & pop & ~push;
   assign push_ok   = op_push & ~full;
   assign pop_ok    = op_pop & ~empty;
   assign pop_empty = op_pop & empty;

   // When sp == DEPTH the low bits wrap to 0, so sp-1 still lands on the top entry.
   assign wr_addr   = sp_q[AW-1:0];
   assign rd_addr   = sp_q[AW-1:0] - ADDR_ONE;

   // Next-state logic for the pointer and the sticky flags.
   always_comb begin
      sp_d  = sp_q;
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (clear) begin
         sp_d  = '0;
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else begin
         if (push_ok)        sp_d  = sp_q + SP_ONE;
         if (op_push & full) ovf_d = 1'b1;
         if (pop_ok)         sp_d  = sp_q - SP_ONE;
         if (pop_empty)      unf_d = 1'b1;
      end
   end

   // Pointer and flag registers. Reset empties the stack without touching storage.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sp_q  <= '0;
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         sp_q  <= sp_d;
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   // Storage write port. It has no reset: a write on an edge where reset is held
   // low lands at or above sp = 0 and is never read before it is pushed again.
   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_addr] <= d;
   end

   // Read port and pop data register. An empty pop returns zero. Clear leaves q alone.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_q <= '0;
      end else if (pop_ok) begin
         q_q <= mem_q[rd_addr];
      end else if (pop_empty) begin
         q_q <= '0;
      end
   end

   assign q         = q_q;
   assign level     = sp_q;
   assign overflow  = ovf_q;
   assign underflow = unf_q;

endmodule
